// File: rtl/ppi_pkg.sv
// Shared definitions for the 8255A-style PPI read/write controller:
// FSM encodings, register addresses and control-word field positions.
package ppi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_C    = 2'd2;
  localparam logic [1:0] ADDR_CTRL = 2'd3;

  localparam logic [7:0] CTRL_RESET_DEFAULT = 8'h9B;

  localparam int MODE_FLAG   = 7;
  localparam int BSR_BIT_MSB = 3;
  localparam int BSR_BIT_LSB = 1;
  localparam int BSR_VAL_POS = 0;

  function automatic logic [2:0] port_onehot(input logic [1:0] addr);
    logic [2:0] sel;
    case (addr)
      ADDR_A:  sel = 3'b001;
      ADDR_B:  sel = 3'b010;
      ADDR_C:  sel = 3'b100;
      default: sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ppi_sync.sv
// N-stage synchronizer for asynchronous CPU-side pins; resets to all-ones
// so active-low strobes read as inactive. STAGES=0 passes inputs straight through.
module ppi_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [STAGES*WIDTH-1:0] chain_q;
    logic [STAGES*WIDTH-1:0] chain_d;

    always_comb begin
      chain_d = chain_q;
      chain_d[WIDTH-1:0] = d;
      for (int i = 1; i < STAGES; i++) begin
        chain_d[i*WIDTH +: WIDTH] = chain_q[(i-1)*WIDTH +: WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        chain_q <= '1;
      end else begin
        chain_q <= chain_d;
      end
    end

    assign q = chain_q[(STAGES-1)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/ppi_rw_control.sv
// PPI read/write sequencer: steers the data buffer, issues one-cycle port
// write strobes, holds the control word and decodes port C bit set/reset.
module ppi_rw_control
  import ppi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CTRL_RESET  = CTRL_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic [1:0] a,
  input  logic [7:0] din,
  output logic       buf_dir,
  output logic       rd_en,
  output logic [1:0] rd_sel,
  output logic [2:0] wr_stb,
  output logic [7:0] wr_data,
  output logic [7:0] ctrl_word,
  output logic       mode_stb,
  output logic       bsr_stb,
  output logic [2:0] bsr_bit,
  output logic       bsr_val,
  output logic       err_stb
);

  logic [2:0] strb_s;
  logic [1:0] s_a;
  logic       s_cs, s_rd, s_wr;

  ppi_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_sync_strb (
    .clk   (clk),
    .reset (reset),
    .d     ({cs_n, rd_n, wr_n}),
    .q     (strb_s)
  );

  ppi_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_sync_addr (
    .clk   (clk),
    .reset (reset),
    .d     (a),
    .q     (s_a)
  );

  assign s_cs = strb_s[2];
  assign s_rd = strb_s[1];
  assign s_wr = strb_s[0];

  state_e     state_q, state_d;
  logic [1:0] rd_sel_q, rd_sel_d;
  logic       buf_dir_q, buf_dir_d;
  logic       rd_en_q, rd_en_d;
  logic [2:0] wr_stb_q, wr_stb_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic [7:0] ctrl_word_q, ctrl_word_d;
  logic       mode_stb_q, mode_stb_d;
  logic       bsr_stb_q, bsr_stb_d;
  logic [2:0] bsr_bit_q, bsr_bit_d;
  logic       bsr_val_q, bsr_val_d;
  logic       err_stb_q, err_stb_d;
  logic       err_lock_q, err_lock_d;
  logic       illegal_s;

  assign illegal_s = !s_cs && !s_rd && !s_wr;

  always_comb begin
    state_d     = state_q;
    rd_sel_d    = rd_sel_q;
    buf_dir_d   = 1'b1;
    rd_en_d     = 1'b0;
    wr_stb_d    = 3'b000;
    wr_data_d   = wr_data_q;
    wr_addr_d   = wr_addr_q;
    ctrl_word_d = ctrl_word_q;
    mode_stb_d  = 1'b0;
    bsr_stb_d   = 1'b0;
    bsr_bit_d   = bsr_bit_q;
    bsr_val_d   = bsr_val_q;
    err_stb_d   = 1'b0;
    err_lock_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A held rd+wr collision flags once, not on every cycle it persists.
        if (illegal_s) begin
          err_stb_d  = !err_lock_q;
          err_lock_d = 1'b1;
        end else if (!s_cs && !s_rd) begin
          state_d  = READ;
          rd_sel_d = s_a;
          if (s_a == ADDR_CTRL) begin
            err_stb_d = 1'b1;
          end else begin
            buf_dir_d = 1'b0;
            rd_en_d   = 1'b1;
          end
        end else if (!s_cs && !s_wr) begin
          state_d   = WRITE;
          wr_data_d = din;
          wr_addr_d = s_a;
        end else begin
          state_d = IDLE;
        end
      end

      READ: begin
        if (s_rd || s_cs) begin
          state_d = IDLE;
        end else if (rd_sel_q != ADDR_CTRL) begin
          buf_dir_d = 1'b0;
          rd_en_d   = 1'b1;
        end else begin
          state_d = READ;
        end
      end

      WRITE: begin
        // Commit uses the data/address captured while the strobe was still low.
        if (s_wr) begin
          state_d = COMMIT;
          if (wr_addr_q != ADDR_CTRL) begin
            wr_stb_d = port_onehot(wr_addr_q);
          end else if (wr_data_q[MODE_FLAG]) begin
            ctrl_word_d = wr_data_q;
            mode_stb_d  = 1'b1;
          end else begin
            bsr_stb_d = 1'b1;
            bsr_bit_d = wr_data_q[BSR_BIT_MSB:BSR_BIT_LSB];
            bsr_val_d = wr_data_q[BSR_VAL_POS];
          end
        end else if (s_cs) begin
          state_d   = IDLE;
          err_stb_d = 1'b1;
        end else begin
          wr_data_d = din;
          wr_addr_d = s_a;
        end
      end

      COMMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rd_sel_q    <= 2'd0;
      buf_dir_q   <= 1'b1;
      rd_en_q     <= 1'b0;
      wr_stb_q    <= 3'b000;
      wr_data_q   <= 8'h00;
      wr_addr_q   <= ADDR_A;
      ctrl_word_q <= CTRL_RESET;
      mode_stb_q  <= 1'b0;
      bsr_stb_q   <= 1'b0;
      bsr_bit_q   <= 3'd0;
      bsr_val_q   <= 1'b0;
      err_stb_q   <= 1'b0;
      err_lock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_sel_q    <= rd_sel_d;
      buf_dir_q   <= buf_dir_d;
      rd_en_q     <= rd_en_d;
      wr_stb_q    <= wr_stb_d;
      wr_data_q   <= wr_data_d;
      wr_addr_q   <= wr_addr_d;
      ctrl_word_q <= ctrl_word_d;
      mode_stb_q  <= mode_stb_d;
      bsr_stb_q   <= bsr_stb_d;
      bsr_bit_q   <= bsr_bit_d;
      bsr_val_q   <= bsr_val_d;
      err_stb_q   <= err_stb_d;
      err_lock_q  <= err_lock_d;
    end
  end

  assign buf_dir   = buf_dir_q;
  assign rd_en     = rd_en_q;
  assign rd_sel    = rd_sel_q;
  assign wr_stb    = wr_stb_q;
  assign wr_data   = wr_data_q;
  assign ctrl_word = ctrl_word_q;
  assign mode_stb  = mode_stb_q;
  assign bsr_stb   = bsr_stb_q;
  assign bsr_bit   = bsr_bit_q;
  assign bsr_val   = bsr_val_q;
  assign err_stb   = err_stb_q;

endmodule

// File: doc/ppi_rw_control.md
Name: ppi_rw_control

Overview:
- Clocked read/write controller for the 8255A-style PPI.
- Samples the CPU strobes (cs_n, rd_n, wr_n, a) and sequences the data bus buffer direction.
- Emits one-cycle write strobes toward ports A/B/C.
- Holds the control word register and decodes Bit Set/Reset (BSR) commands for port C.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on cs_n/rd_n/wr_n/a; legal 0..3 (0 = inputs used directly).
- CTRL_RESET, 8'h9B, control word value after reset (mode 0, all ports input).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- cs_n  input  1  chip select, active low.
- rd_n  input  1  CPU read strobe, active low.
- wr_n  input  1  CPU write strobe, active low.
- a  input  2  register address: 0=A, 1=B, 2=C, 3=control.
- din  input  8  internal-side data from buffer during CPU writes.
- buf_dir  output  1  buffer direction: 1 = CPU→ports (idle/write), 0 = ports→CPU (read).
- rd_en  output  1  high while a valid read is active.
- rd_sel  output  2  port selected for read, valid when rd_en=1.
- wr_stb  output  3  one-hot one-cycle write pulse: bit0=A, bit1=B, bit2=C.
- wr_data  output  8  data committed with wr_stb/bsr_stb/mode_stb.
- ctrl_word  output  8  current control word.
- mode_stb  output  1  one-cycle pulse when a mode-set control word is loaded.
- bsr_stb  output  1  one-cycle pulse on a BSR command.
- bsr_bit  output  3  port C bit index for BSR.
- bsr_val  output  1  value for BSR bit.
- err_stb  output  1  one-cycle pulse on an illegal access.

Behaviour:
- Reset:
  - state=IDLE; buf_dir=1; rd_en=0; rd_sel=0.
  - wr_stb=0, mode_stb=0, bsr_stb=0, err_stb=0; wr_data=0; bsr_bit=0; bsr_val=0.
  - ctrl_word=CTRL_RESET.
  - Synchronizer flops load 1 (inactive). Reset mid-transaction aborts it with no commit.
- Synchronized signals are s_cs, s_rd, s_wr, s_a, all active-low strobes after SYNC_STAGES flops. All outputs are registered.
- IDLE:
  - s_cs=0, s_rd=0, s_wr=1 → READ; latch rd_sel=s_a.
  - s_cs=0, s_wr=0, s_rd=1 → WRITE.
  - s_cs=0, s_rd=0, s_wr=0 → err_stb pulse; stay IDLE.
- READ:
  - If rd_sel≠3: buf_dir=0 and rd_en=1 from the first READ cycle. Latency from the rd_n pin falling to buf_dir=0 is SYNC_STAGES+1 clocks.
  - If rd_sel=3 (control word is not readable): err_stb pulses once on entry; buf_dir stays 1; rd_en=0.
  - s_rd=1 or s_cs=1 → IDLE. buf_dir returns to 1 and rd_en to 0 on the next edge.
- WRITE:
  - buf_dir=1; wr_data<=din every cycle, so the last value before release is committed.
  - s_a is re-sampled each cycle; the final value is used.
  - s_wr=1 (regardless of s_cs) → COMMIT.
  - s_cs=1 while s_wr=0 → abort to IDLE; no strobe; err_stb pulse.
- COMMIT (exactly 1 cycle, then IDLE):
  - a∈{0,1,2} → wr_stb[a]=1.
  - a=3, wr_data[7]=1 → ctrl_word<=wr_data; mode_stb=1.
  - a=3, wr_data[7]=0 → bsr_stb=1; bsr_bit=wr_data[3:1]; bsr_val=wr_data[0]; ctrl_word unchanged.
- Back-to-back accesses: a new access is accepted only from IDLE. COMMIT always costs one cycle, so the minimum strobe-high time between transactions is 1 clk plus sync delay.
- Strobes are mutually exclusive; at most one of wr_stb/mode_stb/bsr_stb/err_stb is high per cycle.
- rd_n/wr_n changes while s_cs=1 are ignored.

Decomposition:
- Shared package/include ppi_pkg holds:
  - State encodings IDLE=2'd0, READ=2'd1, WRITE=2'd2, COMMIT=2'd3.
  - Address constants ADDR_A/B/C/CTRL.
  - CTRL_RESET default.
  - Control-word field positions: MODE_FLAG=7, BSR bit field [3:1], BSR value bit 0.
- Sub-module ppi_sync: N-stage synchronizer, width parameter, reset value all-ones. Instantiated once for {cs_n, rd_n, wr_n} and once for a.

Test Plan (SYNC_STAGES=2):
- Reset release → ctrl_word=8'h9B, buf_dir=1, all strobes 0 for 10 idle cycles.
- Write a=1, din=8'h5A, wr_n low 4 clks then high → exactly one wr_stb=3'b010 with wr_data=8'h5A, 3 clks after wr_n rises; no other strobe.
- Write a=3, din=8'h80 → mode_stb once, ctrl_word=8'h80. Then write a=3, din=8'h0B → bsr_stb once, bsr_bit=5, bsr_val=1, ctrl_word still 8'h80.
- Read a=2, rd_n low 5 clks → buf_dir=0, rd_en=1, rd_sel=2 starting 3 clks after rd_n falls; buf_dir=1 3 clks after rd_n rises. Read a=3 → err_stb once, buf_dir stays 1.
- Write a=0 with cs_n rising while wr_n still low → no wr_stb, err_stb once, state IDLE. Write with cs_n and wr_n rising same clk → wr_stb=3'b001.
- reset asserted during WRITE (wr_n low) → no strobe on release, ctrl_word=8'h9B. rd_n=wr_n=0 with cs_n=0 → err_stb, buf_dir stays 1.
